// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM encoding,
// scoreboard entry layout and the NOP field values loaded into ID/EX.
package pipe_seq_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned WAIT_W  = 10;
  localparam int unsigned STALL_W = 32;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
  } stage_entry_t;

  localparam logic       NOP_WB_EN       = 1'b0;
  localparam logic       NOP_MEM_SIGNAL  = 1'b0;
  localparam logic [1:0] NOP_BRANCH_TYPE = 2'b00;

  // True when an in-flight writer produces the register a source reads.
  function automatic logic src_match(input stage_entry_t e,
                                     input logic [REG_W-1:0] src,
                                     input logic r0_zero);
    return e.valid && (e.dest == src) && !(r0_zero && (src == '0));
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-entry destination scoreboard (EXE, MEM) and the RAW hazard compare
// for the two ID source operands.
module hazard_scoreboard
  import pipe_seq_pkg::*;
#(
  parameter logic R0_IS_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             ins_valid,
  input  logic [REG_W-1:0] ins_dest,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             src1_used,
  input  logic             src2_used,
  output logic             hazard
);

  stage_entry_t ex_q;
  stage_entry_t mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else if (!hold) begin
      mem_q <= ex_q;
      ex_q  <= {ins_valid, ins_dest};
    end
  end

  logic match1;
  logic match2;

  assign match1 = src_match(ex_q, src1, R0_IS_ZERO) | src_match(mem_q, src1, R0_IS_ZERO);
  assign match2 = src_match(ex_q, src2, R0_IS_ZERO) | src_match(mem_q, src2, R0_IS_ZERO);
  assign hazard = (src1_used & match1) | (src2_used & match2);

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: RAW stall, branch flush and data-memory freeze
// control for the 5-stage core, plus timeout and stall-count bookkeeping.
module pipe_sequencer
  import pipe_seq_pkg::*;
#(
  parameter logic        R0_IS_ZERO  = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   id_src1,
  input  logic [REG_W-1:0]   id_src2,
  input  logic               id_src1_used,
  input  logic               id_src2_used,
  input  logic               id_wb_en,
  input  logic [REG_W-1:0]   id_dest,
  input  logic               br_taken,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               pc_freeze,
  output logic               ifid_freeze,
  output logic               flush,
  output logic               idex_bubble,
  output logic               pipe_freeze,
  output logic               mem_err,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  logic [0:0]         state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               err_q, err_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic hazard;
  logic mem_stall;
  logic ins_valid;

  assign mem_stall = mem_req & ~mem_ready;
  assign ins_valid = id_wb_en & ~idex_bubble & ~flush;

  hazard_scoreboard #(
    .R0_IS_ZERO (R0_IS_ZERO)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .hold      (pipe_freeze),
    .ins_valid (ins_valid),
    .ins_dest  (id_dest),
    .src1      (id_src1),
    .src2      (id_src2),
    .src1_used (id_src1_used),
    .src2_used (id_src2_used),
    .hazard    (hazard)
  );

  // Next state, counters and the priority mux: mem stall > branch > hazard.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    err_d       = err_q;
    stall_d     = stall_q;
    pc_freeze   = 1'b0;
    ifid_freeze = 1'b0;
    flush       = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    mem_err     = err_q & ~rst;

    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
        end else if (mem_stall && (wait_q != TIMEOUT_CNT)) begin
          wait_d = wait_q + WAIT_W'(1);
          if ((wait_q + WAIT_W'(1)) == TIMEOUT_CNT) err_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (!rst) begin
      if (mem_stall) begin
        pipe_freeze = 1'b1;
        pc_freeze   = 1'b1;
        ifid_freeze = 1'b1;
      end else if (br_taken) begin
        flush       = 1'b1;
        idex_bubble = 1'b1;
      end else if (hazard) begin
        pc_freeze   = 1'b1;
        ifid_freeze = 1'b1;
        idex_bubble = 1'b1;
        if (stall_q != '1) stall_d = stall_q + STALL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Pipeline sequencer for the 5-stage MIPS-style core. It tracks the destination registers of in-flight writers in EXE and MEM, and stalls ID on read-after-write hazards, since the core has no forwarding. It flushes IF/ID on taken branches and freezes the whole pipeline while the MEM stage waits on a slow data memory. It drives the freeze/flush inputs of the PC, IF/ID and ID/EX stage registers.

## Interface
- `R0_IS_ZERO`, 1, when 1 a source or destination of register 0 never creates a hazard.
- `MEM_TIMEOUT`, 255, MEM_WAIT cycles before `mem_err` sets; range 1..1023.
- `clk` in 1, single clock, all state updates on rising edge.
- `rst` in 1, synchronous, active-high reset.
- `id_src1` in 5, ID rs field (instruction[25:21]).
- `id_src2` in 5, ID rt field (instruction[20:16]).
- `id_src1_used` in 1, ID instruction reads src1.
- `id_src2_used` in 1, ID instruction reads src2 (register-form ALU, ST, BNE).
- `id_wb_en` in 1, ID instruction writes back (controller WB_En).
- `id_dest` in 5, ID destination after the dest mux.
- `br_taken` in 1, EXE resolved a taken branch or JMP this cycle.
- `mem_req` in 1, MEM stage holds LD or ST.
- `mem_ready` in 1, data memory completes the access this cycle.
- `pc_freeze` out 1, hold the PC.
- `ifid_freeze` out 1, hold the IF/ID register.
- `flush` out 1, clear IF/ID; feeds the ID flushIn path.
- `idex_bubble` out 1, load a NOP (WB_EN=0, MEM_Signal=0, Branch_Type=0) into ID/EX.
- `pipe_freeze` out 1, hold ID/EX, EXE/MEM and MEM/WB.
- `mem_err` out 1, sticky memory-timeout flag.
- `stall_cycles` out 32, saturating count of hazard-stall cycles.

## Operation
- Scoreboard has two entries, `ex` and `mem`, each holding {valid, dest}.
- When `pipe_freeze`=0, on every edge:
  - `mem` <= `ex`.
  - `ex` <= {`id_wb_en` & !`idex_bubble` & !`flush`, `id_dest`}.
- When `pipe_freeze`=1, the scoreboard holds.
- No WB entry is tracked: the register file writes on negedge, so an ID read in the same cycle sees the new value.
- `hazard` = (src1 used & match) | (src2 used & match).
  - A match means the source equals a valid `ex.dest` or `mem.dest`.
  - With `R0_IS_ZERO`=1, register 0 never matches.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when `mem_req` & !`mem_ready`.
  - MEM_WAIT -> RUN when `mem_ready`.
  - MEM_WAIT holds a 10-bit wait counter, cleared on entry. Counter reaching `MEM_TIMEOUT` sets `mem_err`; it stays in MEM_WAIT.
- `mem_stall` = `mem_req` & !`mem_ready`, in either state.
- Priority, highest first: `mem_stall`, then `br_taken`, then `hazard`.
  - `mem_stall`: `pipe_freeze`=`pc_freeze`=`ifid_freeze`=1; `flush`=`idex_bubble`=0.
  - `br_taken` (no mem_stall): `flush`=1 and `idex_bubble`=1; PC not frozen, so the branch target loads.
  - `hazard` only: `pc_freeze`=`ifid_freeze`=1 and `idex_bubble`=1; `stall_cycles` increments and saturates at 0xFFFFFFFF.
- `br_taken` held during a mem stall is serviced on the first cycle `mem_stall` drops, because EXE stays frozen.
- `mem_err` clears only on `rst`.

## Timing
- All control outputs are combinational from registered scoreboard/FSM state plus current inputs, so they are valid in the same cycle. No extra latency.
- Load-use or ALU-use hazard with the producer in EXE: 2 stall cycles. With the producer in MEM: 1 stall cycle.
- Reset (synchronous, `rst`=1 at an edge):
  - Scoreboard entries invalid, state RUN, wait counter 0, `mem_err`=0, `stall_cycles`=0.
  - While `rst`=1, all 1-bit outputs are forced to 0.
- Reset mid MEM_WAIT returns to RUN with no residual freeze on the next cycle.
- `mem_ready` and `mem_req` rising in the same cycle: no stall, and the FSM stays in RUN.

## Structure
- Package `pipe_seq_pkg` holds:
  - State enum {RUN, MEM_WAIT}.
  - Stage-entry struct {valid, dest[4:0]}.
  - NOP field constants.
- Sub-module `hazard_scoreboard` holds the two entries, the shift/hold/insert logic and the `hazard` compare.
- The top module holds the FSM, the priority mux and the counters.

## Test plan
- ADD r5 in ID, then ADD r6 using r5: `hazard` for 2 cycles, `idex_bubble`=1 both cycles, `stall_cycles`=2, and the third cycle issues.
- ADDI r3 followed by a source of r0 with `R0_IS_ZERO`=1: no stall ever. Write to r0 then read r0: no stall.
- `br_taken`=1 for 1 cycle with a hazard also present: `flush`=1, `idex_bubble`=1, `pc_freeze`=0, `stall_cycles` unchanged.
- LD in MEM with `mem_ready` low 4 cycles: `pipe_freeze`=1 for exactly 4 cycles, state MEM_WAIT, scoreboard unchanged, return to RUN on ready.
- `MEM_TIMEOUT`=3 and `mem_ready` never asserted: `mem_err`=1 after the 3rd wait cycle; `rst` clears it and all outputs read 0.
- `br_taken` arriving during a mem stall: `flush`=0 while frozen, then `flush`=1 on the first cycle `mem_ready`=1.
